// File: rtl/ebpc_pkg.sv
// Shared EBPC definitions: stream widths and the decoder arbiter's state encoding.
package ebpc_pkg;

    localparam int unsigned LOG_MAX_WORDS = 24;
    localparam int unsigned DEC_ARB_LEN_W = 16;

    typedef enum logic {
        IDLE,
        ACTIVE
    } dec_arb_state_e;

endpackage

// File: rtl/ebpc_decoder_arb_if.sv
// Requester-side and decoder-side stream bundle of the shared decoder arbiter.
interface ebpc_decoder_arb_if
    import ebpc_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NW_W   = LOG_MAX_WORDS,
    parameter int unsigned LEN_W  = DEC_ARB_LEN_W
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]             req_i;
    logic [N_REQ-1:0][LEN_W-1:0]  job_len_i;
    logic [N_REQ-1:0]             gnt_o;
    logic [N_REQ-1:0]             done_o;

    logic [N_REQ-1:0][NW_W-1:0]   num_words_i;
    logic [N_REQ-1:0]             num_words_vld_i;
    logic [N_REQ-1:0]             num_words_rdy_o;
    logic [N_REQ-1:0][DATA_W-1:0] bpc_i;
    logic [N_REQ-1:0]             bpc_vld_i;
    logic [N_REQ-1:0]             bpc_rdy_o;
    logic [N_REQ-1:0][DATA_W-1:0] znz_i;
    logic [N_REQ-1:0]             znz_vld_i;
    logic [N_REQ-1:0]             znz_rdy_o;

    logic [DATA_W-1:0]            data_o;
    logic [N_REQ-1:0]             vld_o;
    logic [N_REQ-1:0]             rdy_i;

    logic [NW_W-1:0]              dec_num_words_o;
    logic                         dec_num_words_vld_o;
    logic                         dec_num_words_rdy_i;
    logic [DATA_W-1:0]            dec_bpc_o;
    logic                         dec_bpc_vld_o;
    logic                         dec_bpc_rdy_i;
    logic [DATA_W-1:0]            dec_znz_o;
    logic                         dec_znz_vld_o;
    logic                         dec_znz_rdy_i;
    logic [DATA_W-1:0]            dec_data_i;
    logic                         dec_vld_i;
    logic                         dec_rdy_o;

    logic                         busy_o;
    logic [ID_W-1:0]              cur_id_o;

    modport slave (
        input  req_i, job_len_i,
        input  num_words_i, num_words_vld_i, bpc_i, bpc_vld_i, znz_i, znz_vld_i,
        input  rdy_i,
        input  dec_num_words_rdy_i, dec_bpc_rdy_i, dec_znz_rdy_i, dec_data_i, dec_vld_i,
        output gnt_o, done_o,
        output num_words_rdy_o, bpc_rdy_o, znz_rdy_o,
        output data_o, vld_o,
        output dec_num_words_o, dec_num_words_vld_o, dec_bpc_o, dec_bpc_vld_o,
        output dec_znz_o, dec_znz_vld_o, dec_rdy_o,
        output busy_o, cur_id_o
    );

    modport master (
        output req_i, job_len_i,
        output num_words_i, num_words_vld_i, bpc_i, bpc_vld_i, znz_i, znz_vld_i,
        output rdy_i,
        output dec_num_words_rdy_i, dec_bpc_rdy_i, dec_znz_rdy_i, dec_data_i, dec_vld_i,
        input  gnt_o, done_o,
        input  num_words_rdy_o, bpc_rdy_o, znz_rdy_o,
        input  data_o, vld_o,
        input  dec_num_words_o, dec_num_words_vld_o, dec_bpc_o, dec_bpc_vld_o,
        input  dec_znz_o, dec_znz_vld_o, dec_rdy_o,
        input  busy_o, cur_id_o
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping around.
module rr_pick #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Rotating a doubled copy puts requester ptr_i at bit 0.
    logic [N_REQ-1:0] req_rot;
    assign req_rot = N_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!any_o && req_rot[k]) begin
                any_o = 1'b1;
                idx_o = ID_W'((32'(ptr_i) + k) % N_REQ);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            gnt_o[i] = any_o && (idx_o == ID_W'(i));
        end
    end

endmodule

// File: rtl/ebpc_decoder_arb.sv
// Shares one EBPC decoder between N_REQ requesters, one whole job at a time,
// with round-robin selection and zero-latency stream routing while a job runs.
module ebpc_decoder_arb
    import ebpc_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NW_W   = LOG_MAX_WORDS,
    parameter int unsigned LEN_W  = DEC_ARB_LEN_W
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ebpc_decoder_arb_if.slave   bus
);

    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    dec_arb_state_e   state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [LEN_W-1:0] pick_len;

    logic             active, route, hs, last;
    logic [NW_W-1:0]  nw_sel;
    logic [DATA_W-1:0] bpc_sel, znz_sel;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        pick_len = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) pick_len |= bus.job_len_i[i];
        end
    end

    // A zero-length job holds the grant for one cycle but never opens the streams.
    assign active = (state_q == ACTIVE);
    assign route  = active && (len_q != '0);
    assign hs     = route && bus.dec_vld_i && bus.rdy_i[id_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = ACTIVE;
                    id_d    = pick_idx;
                    len_d   = pick_len;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (len_q == '0) begin
                    last = 1'b1;
                end else if (hs) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    last  = (cnt_q == len_q - LEN_W'(1));
                end
                if (last) begin
                    state_d = IDLE;
                    ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt_o           = '0;
        bus.done_o          = '0;
        bus.vld_o           = '0;
        bus.num_words_rdy_o = '0;
        bus.bpc_rdy_o       = '0;
        bus.znz_rdy_o       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (active && (id_q == ID_W'(i))) begin
                bus.gnt_o[i]           = 1'b1;
                bus.done_o[i]          = last;
                bus.vld_o[i]           = route && bus.dec_vld_i;
                bus.num_words_rdy_o[i] = route && bus.dec_num_words_rdy_i;
                bus.bpc_rdy_o[i]       = route && bus.dec_bpc_rdy_i;
                bus.znz_rdy_o[i]       = route && bus.dec_znz_rdy_i;
            end
        end
    end

    assign nw_sel  = bus.num_words_i[id_q];
    assign bpc_sel = bus.bpc_i[id_q];
    assign znz_sel = bus.znz_i[id_q];

    assign bus.dec_num_words_o     = route ? nw_sel : '0;
    assign bus.dec_num_words_vld_o = route && bus.num_words_vld_i[id_q];
    assign bus.dec_bpc_o           = route ? bpc_sel : '0;
    assign bus.dec_bpc_vld_o       = route && bus.bpc_vld_i[id_q];
    assign bus.dec_znz_o           = route ? znz_sel : '0;
    assign bus.dec_znz_vld_o       = route && bus.znz_vld_i[id_q];
    assign bus.data_o              = route ? bus.dec_data_i : '0;
    assign bus.dec_rdy_o           = route && bus.rdy_i[id_q];
    assign bus.busy_o              = active;
    assign bus.cur_id_o            = active ? id_q : '0;

endmodule

// File: tb/tb_ebpc_decoder_arb.sv
// Self-checking bench for ebpc_decoder_arb: directed jobs plus randomized traffic
// compared cycle by cycle against a job-level reference model.
module tb_ebpc_decoder_arb;
    import ebpc_pkg::*;

    localparam int unsigned N   = 2;
    localparam int unsigned DW  = 8;
    localparam int unsigned NWW = LOG_MAX_WORDS;
    localparam int unsigned LW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ebpc_decoder_arb_if #(.N_REQ(N), .DATA_W(DW), .NW_W(NWW), .LEN_W(LW)) bus ();

    ebpc_decoder_arb #(
        .N_REQ  (N),
        .DATA_W (DW),
        .NW_W   (NWW),
        .LEN_W  (LW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which job is running, its declared length, words handed over so far.
    bit          m_busy;
    int unsigned m_id, m_len, m_words, m_ptr;
    bit          e_hs, e_last;
    int unsigned obs_words [N];

    task automatic model_reset();
        m_busy  = 1'b0;
        m_id    = 0;
        m_len   = 0;
        m_words = 0;
        m_ptr   = 0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt, e_done, e_vld, e_nwr, e_bpr, e_znr;
        bit route;
        route  = m_busy && (m_len != 0);
        e_hs   = route && bus.dec_vld_i && bus.rdy_i[m_id];
        e_last = m_busy && ((m_len == 0) || (e_hs && (m_words + 1 == m_len)));
        for (int i = 0; i < N; i++) begin
            e_gnt[i]  = m_busy && (m_id == i);
            e_done[i] = e_gnt[i] && e_last;
            e_vld[i]  = route && (m_id == i) && bus.dec_vld_i;
            e_nwr[i]  = route && (m_id == i) && bus.dec_num_words_rdy_i;
            e_bpr[i]  = route && (m_id == i) && bus.dec_bpc_rdy_i;
            e_znr[i]  = route && (m_id == i) && bus.dec_znz_rdy_i;
        end
        check_eq("gnt",         bus.gnt_o,           e_gnt);
        check_eq("done",        bus.done_o,          e_done);
        check_eq("vld",         bus.vld_o,           e_vld);
        check_eq("nw_rdy",      bus.num_words_rdy_o, e_nwr);
        check_eq("bpc_rdy",     bus.bpc_rdy_o,       e_bpr);
        check_eq("znz_rdy",     bus.znz_rdy_o,       e_znr);
        check_eq("dec_nw",      bus.dec_num_words_o,     route ? bus.num_words_i[m_id] : '0);
        check_eq("dec_nw_vld",  bus.dec_num_words_vld_o, route && bus.num_words_vld_i[m_id]);
        check_eq("dec_bpc",     bus.dec_bpc_o,           route ? bus.bpc_i[m_id] : '0);
        check_eq("dec_bpc_vld", bus.dec_bpc_vld_o,       route && bus.bpc_vld_i[m_id]);
        check_eq("dec_znz",     bus.dec_znz_o,           route ? bus.znz_i[m_id] : '0);
        check_eq("dec_znz_vld", bus.dec_znz_vld_o,       route && bus.znz_vld_i[m_id]);
        check_eq("data",        bus.data_o,              route ? bus.dec_data_i : '0);
        check_eq("dec_rdy",     bus.dec_rdy_o,           route && bus.rdy_i[m_id]);
        check_eq("busy",        bus.busy_o,              m_busy);
        check_eq("cur_id",      bus.cur_id_o,            m_busy ? m_id : 0);
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            for (int unsigned k = 0; k < N; k++) begin
                int unsigned j;
                j = (m_ptr + k) % N;
                if (bus.req_i[j]) begin
                    m_busy  = 1'b1;
                    m_id    = j;
                    m_len   = bus.job_len_i[j];
                    m_words = 0;
                    break;
                end
            end
        end else begin
            if (e_hs) m_words++;
            if (e_last) begin
                m_busy = 1'b0;
                m_ptr  = (m_id + 1) % N;
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        check_outputs();
        for (int i = 0; i < N; i++) begin
            if (bus.vld_o[i] && bus.rdy_i[i]) obs_words[i]++;
        end
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic drop_granted();
        for (int unsigned i = 0; i < N; i++) begin
            if (m_busy && m_id == i) bus.req_i[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_streams_directed();
        for (int i = 0; i < N; i++) begin
            bus.num_words_i[i] = NWW'(32'h100 + i);
            bus.bpc_i[i]       = DW'(8'hB0 + i);
            bus.znz_i[i]       = DW'(8'hC0 + i);
        end
        bus.num_words_vld_i     = '1;
        bus.bpc_vld_i           = '1;
        bus.znz_vld_i           = '1;
        bus.dec_num_words_rdy_i = 1'b1;
        bus.dec_bpc_rdy_i       = 1'b1;
        bus.dec_znz_rdy_i       = 1'b1;
    endtask

    task automatic run_directed(input int unsigned cycles, input bit toggle_rdy);
        for (int unsigned c = 0; c < cycles; c++) begin
            drop_granted();
            bus.dec_vld_i  = 1'b1;
            bus.dec_data_i = DW'(8'h11 * (m_words + 1));
            bus.rdy_i      = (toggle_rdy && (c % 2 == 1)) ? '0 : '1;
            step();
        end
    endtask

    task automatic rand_inputs();
        for (int unsigned i = 0; i < N; i++) begin
            if (m_busy && m_id == i) bus.req_i[i] = 1'b0;
            else if (!bus.req_i[i])  bus.req_i[i] = ($urandom_range(0, 3) == 0);
            bus.job_len_i[i]       = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom_range(1, 6));
            bus.num_words_i[i]     = NWW'($urandom);
            bus.bpc_i[i]           = DW'($urandom);
            bus.znz_i[i]           = DW'($urandom);
            bus.num_words_vld_i[i] = $urandom_range(0, 1) == 1;
            bus.bpc_vld_i[i]       = $urandom_range(0, 1) == 1;
            bus.znz_vld_i[i]       = $urandom_range(0, 1) == 1;
            bus.rdy_i[i]           = $urandom_range(0, 3) != 0;
        end
        bus.dec_num_words_rdy_i = $urandom_range(0, 1) == 1;
        bus.dec_bpc_rdy_i       = $urandom_range(0, 1) == 1;
        bus.dec_znz_rdy_i       = $urandom_range(0, 1) == 1;
        bus.dec_vld_i           = $urandom_range(0, 2) != 0;
        bus.dec_data_i          = DW'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w0;
        rst                     = 1'b1;
        bus.req_i               = '0;
        bus.job_len_i           = '0;
        bus.num_words_i         = '0;
        bus.num_words_vld_i     = '0;
        bus.bpc_i               = '0;
        bus.bpc_vld_i           = '0;
        bus.znz_i               = '0;
        bus.znz_vld_i           = '0;
        bus.rdy_i               = '0;
        bus.dec_num_words_rdy_i = 1'b0;
        bus.dec_bpc_rdy_i       = 1'b0;
        bus.dec_znz_rdy_i       = 1'b0;
        bus.dec_data_i          = '0;
        bus.dec_vld_i           = 1'b0;
        for (int i = 0; i < N; i++) obs_words[i] = 0;
        @(negedge clk);
        do_reset();
        set_streams_directed();

        // Single requester, four words, requester 1 streams present but not granted.
        bus.req_i        = 2'b01;
        bus.job_len_i[0] = LW'(4);
        w0 = obs_words[0];
        run_directed(8, 1'b0);
        check_eq("single_words", obs_words[0] - w0, 4);
        check_eq("single_idle",  bus.busy_o, 1'b0);

        // Simultaneous requests from reset: 0 first, then 1.
        do_reset();
        bus.req_i        = 2'b11;
        bus.job_len_i[0] = LW'(3);
        bus.job_len_i[1] = LW'(3);
        run_directed(12, 1'b0);
        check_eq("simul_words1", obs_words[1], 3);

        // Backpressure: ready toggles every cycle.
        bus.req_i        = 2'b01;
        bus.job_len_i[0] = LW'(4);
        w0 = obs_words[0];
        run_directed(12, 1'b1);
        check_eq("bp_words", obs_words[0] - w0, 4);

        // Zero-length job.
        bus.req_i        = 2'b01;
        bus.job_len_i[0] = '0;
        w0 = obs_words[0];
        run_directed(4, 1'b0);
        check_eq("len0_words", obs_words[0] - w0, 0);

        // Randomized traffic.
        for (int unsigned c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end

        // Drain, then reset in the middle of a five-word job.
        bus.req_i = '0;
        set_streams_directed();
        run_directed(10, 1'b0);
        bus.req_i        = 2'b01;
        bus.job_len_i[0] = LW'(5);
        for (int unsigned c = 0; c < 20; c++) begin
            if (m_busy && m_words == 2) break;
            run_directed(1, 1'b0);
        end
        check_eq("mid_words", m_words, 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        bus.req_i        = 2'b10;
        bus.job_len_i[1] = LW'(2);
        rst = 1'b0;
        step();
        check_eq("rst_regrant", bus.gnt_o, 2'b10);
        run_directed(6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
